// File: rtl/alu_pkg.sv
// Definitions shared by the multiplier datapath and its BCD readout converter:
// converter FSM states, double-dabble adjust constants and the product width.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ        = 3;
    localparam int unsigned PRODUCT_WIDTH  = 12;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import alu_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'(BCD_ADJ_THRESH)) begin
            adjusted = digit + 4'(BCD_ADJ);
        end
    end

endmodule

// File: rtl/mul_bcd_converter.sv
// Iterative shift-add-3 converter from the multiplier's binary product to packed
// BCD, with valid/ready handshakes on both the product and the result side.
module mul_bcd_converter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = PRODUCT_WIDTH,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  carry_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned AW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (pow10(DIGITS) <= (64'd1 << WIDTH)) begin : g_param_check
        $error("mul_bcd_converter: DIGITS too small to hold every WIDTH-bit value");
    end

    conv_state_t          state, state_n;
    logic [WIDTH-1:0]     sr;
    logic [AW-1:0]        acc;
    logic [AW-1:0]        acc_adj;
    logic [AW-1:0]        acc_shift;
    logic [WIDTH-1:0]     sr_shift;
    logic [AW+WIDTH-1:0]  cat_shift;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last_iter;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    // Bits leaving the top digit are dropped; the parameter check rules that out.
    assign cat_shift = {acc_adj, sr} << 1;
    assign acc_shift = cat_shift[AW+WIDTH-1:WIDTH];
    assign sr_shift  = cat_shift[WIDTH-1:0];
    assign last_iter = (cnt == CW'(1));
    assign out_valid = (state == DONE);

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            SHIFT:   if (last_iter) state_n = DONE;
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rst) in_ready = 1'b0;
        accept = in_valid && in_ready;
        if (accept) state_n = SHIFT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            acc <= '0;
            cnt <= '0;
            bcd <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            sr  <= bin;
            ovf <= carry_in;
            acc <= '0;
            cnt <= CW'(WIDTH);
        end else if (state == SHIFT) begin
            sr  <= sr_shift;
            acc <= acc_shift;
            cnt <= cnt - CW'(1);
            if (last_iter) bcd <= acc_shift;
        end
    end

endmodule

// File: tb/tb_mul_bcd_converter.sv
// Self-checking bench for mul_bcd_converter against a divide/modulo decimal model.
module tb_mul_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] bin = '0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] bcd;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    mul_bcd_converter #(.WIDTH(12), .DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int unsigned d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a product and returns just after the accepting edge.
    task automatic send(input logic [11:0] b, input logic c);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        bin      = b;
        carry_in = c;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] v1, v2;
        repeat (3) tick();
        n_checks++;
        if (out_valid !== 1'b0 || bcd !== 16'h0000 || ovf !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: ov=%0b bcd=%h ovf=%0b ir=%0b required 0 0000 0 0",
                     out_valid, bcd, ovf, in_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %0b required 1", in_ready);
        end
        tick();
        v1 = 12'($urandom_range(1, 4095));
        send(v1, 1'b0);
        begin
            int lat;
            wait_out(lat);
        end
        n_checks++;
        if (bcd !== to_bcd(v1)) begin
            n_fail++;
            $display("FAIL reset_pre_conv: bin=%0d got %h required %h", v1, bcd, to_bcd(v1));
        end
        pop();
        v2 = 12'($urandom_range(1, 4095));
        send(v2, 1'b1);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || bcd !== 16'h0000 || ovf !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: ov=%0b bcd=%h ovf=%0b ir=%0b required 0 0000 0 0",
                     out_valid, bcd, ovf, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || bcd !== 16'h0000 || ovf !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: cyc=%0d ov=%0b bcd=%h ovf=%0b ir=%0b required 0 0000 0 0",
                         i, out_valid, bcd, ovf, in_ready);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after: ir=%0b ov=%0b required 1 0", in_ready, out_valid);
        end
        tick();
        begin
            bit seen;
            seen = 1'b0;
            repeat (16) begin
                tick();
                if (out_valid) seen = 1'b1;
            end
            n_checks++;
            if (seen !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_discard: out_valid seen=%0b required 0", seen);
            end
        end
    endtask

    task automatic test_max();
        int lat;
        out_ready = 1'b1;
        send(12'd3969, 1'b0);
        wait_out(lat);
        n_checks++;
        if (lat !== 12) begin
            n_fail++;
            $display("FAIL max_latency: got %0d required 12", lat);
        end
        n_checks++;
        if (bcd !== 16'h3969 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL max_value: bcd=%h ovf=%0b required 3969 0", bcd, ovf);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL max_drop: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_boundaries();
        int lat;
        logic [11:0] vals [4];
        logic [15:0] want [4];
        vals = '{12'd0, 12'd4095, 12'd9, 12'd10};
        want = '{16'h0000, 16'h4095, 16'h0009, 16'h0010};
        for (int i = 0; i < 4; i++) begin
            send(vals[i], 1'b0);
            wait_out(lat);
            n_checks++;
            if (bcd !== want[i] || lat !== 12) begin
                n_fail++;
                $display("FAIL boundary: bin=%0d bcd=%h lat=%0d required %h lat 12",
                         vals[i], bcd, lat, want[i]);
            end
            pop();
        end
    endtask

    task automatic test_ovf();
        int lat;
        send(12'd10, 1'b1);
        wait_out(lat);
        n_checks++;
        if (bcd !== 16'h0010 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: bcd=%h ovf=%0b required 0010 1", bcd, ovf);
        end
        pop();
        send(12'd10, 1'b0);
        wait_out(lat);
        n_checks++;
        if (bcd !== 16'h0010 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: bcd=%h ovf=%0b required 0010 0", bcd, ovf);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [11:0] v;
        logic        c;
        logic [15:0] exp_bcd;
        v = 12'($urandom_range(0, 4095));
        c = 1'($urandom);
        exp_bcd = to_bcd(v);
        send(v, c);
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || bcd !== exp_bcd || ovf !== c || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cyc=%0d ov=%0b bcd=%h ovf=%0b ir=%0b required 1 %h %0b 0",
                         i, out_valid, bcd, ovf, in_ready, exp_bcd, c);
            end
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bin       = 12'd1234;
        carry_in  = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handover: ov=%0b ir=%0b required 0 0", out_valid, in_ready);
        end
        wait_out(lat);
        n_checks++;
        if (bcd !== 16'h1234 || lat !== 12 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_b2b: bcd=%h lat=%0d ovf=%0b required 1234 12 0", bcd, lat, ovf);
        end
        pop();
    endtask

    task automatic test_ignored();
        int lat;
        send(12'd25, 1'b0);
        repeat (3) tick();
        in_valid = 1'b1;
        bin      = 12'd777;
        carry_in = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        n_checks++;
        if (bcd !== 16'h0025 || ovf !== 1'b0 || lat !== 8) begin
            n_fail++;
            $display("FAIL ignored_result: bcd=%h ovf=%0b lat=%0d required 0025 0 8", bcd, ovf, lat);
        end
        pop();
        begin
            bit seen;
            seen = 1'b0;
            repeat (16) begin
                tick();
                if (out_valid) seen = 1'b1;
            end
            n_checks++;
            if (seen !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_never: out_valid seen=%0b required 0", seen);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [11:0] v;
        logic        c;
        int unsigned d;
        for (int i = 0; i < 20; i++) begin
            v = 12'($urandom_range(0, 4095));
            c = 1'($urandom);
            d = $urandom_range(0, 3);
            send(v, c);
            wait_out(lat);
            n_checks++;
            if (bcd !== to_bcd(v) || ovf !== c || lat !== 12) begin
                n_fail++;
                $display("FAIL random: bin=%0d bcd=%h ovf=%0b lat=%0d required %h %0b 12",
                         v, bcd, ovf, lat, to_bcd(v), c);
            end
            repeat (d) tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL random_wait: ov=%0b ir=%0b required 1 0", out_valid, in_ready);
            end
            pop();
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] items [6];
        logic        cars  [6];
        logic [16:0] exp_q [$];
        logic [16:0] e;
        int idx, got, last;
        for (int i = 0; i < 6; i++) begin
            items[i] = 12'($urandom_range(0, 4095));
            cars[i]  = 1'($urandom);
        end
        idx = 0;
        got = 0;
        last = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
                n_checks++;
                if ({ovf, bcd} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_value: ovf/bcd=%h required %h", {ovf, bcd}, e);
                end
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last !== 13) begin
                        n_fail++;
                        $display("FAIL b2b_period: got %0d required 13", cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (idx < 6) begin
                in_valid = 1'b1;
                bin      = items[idx];
                carry_in = cars[idx];
                if (in_ready) begin
                    exp_q.push_back({cars[idx], to_bcd(items[idx])});
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (got !== 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results required 6", got);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_max();
        test_boundaries();
        test_ovf();
        test_backpressure();
        test_ignored();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
